dti_boost_tx: RTL and testbench

UART transmitter for the boost (boot-load) channel. It is the transmit counterpart of the boost instruction receiver. It accepts instruction-width words from core-side logic over a req/ready handshake, then serializes each word as consecutive 8N1 UART bytes on the boost TX line, LSB byte first. Transmission honours an active-low CTS input from the host. It sits in the clk domain next to the boost receiver and is used for instruction-memory readback, echo and boot status.

---
 rtl/dti_boost_tx_if.sv | 21 ++
 rtl/dti_boost_tx.sv | 173 +++++++++++++++++
 tb/tb_dti_boost_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dti_boost_tx_if.sv
// Boost channel TX word handshake: core side drives word + request,
// transmitter answers with ready.
interface dti_boost_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tx_data_in;
    logic                  tx_wr_req;
    logic                  tx_ready;

    modport master (
        output tx_data_in,
        output tx_wr_req,
        input  tx_ready
    );

    modport slave (
        input  tx_data_in,
        input  tx_wr_req,
        output tx_ready
    );
endinterface

// File: rtl/dti_boost_tx.sv
// Boost channel UART transmitter: words out as 8N1 bytes, LSB byte first, CTS gated.
// Define DTI_BOOST_TX_PARITY_EN to add an even parity bit per byte.
module dti_boost_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset_n,
    dti_boost_tx_if.slave bus,
    input  logic          cts_n,
    output logic          tx,
    output logic          tx_busy,
    output logic          tx_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(NUM_BYTES - 1);

`ifdef DTI_BOOST_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        WAIT_CTS,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        WAIT_CTS,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t                state;
    logic [CNT_W-1:0]      clk_cnt;
    logic [2:0]            bit_idx;
    logic [BYTE_W-1:0]     byte_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  tx_ready_q;
    logic                  cts_meta;
    logic                  cts_sync;
    logic                  bit_end;
`ifdef DTI_BOOST_TX_PARITY_EN
    logic                  par;
`endif

    assign bus.tx_ready = tx_ready_q;
    assign bit_end      = (clk_cnt == CNT_MAX);

    // Resets to "not clear" so nothing starts before the host is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef DTI_BOOST_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.tx_wr_req && tx_ready_q) begin
                        shreg      <= bus.tx_data_in;
                        byte_idx   <= '0;
                        tx_ready_q <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= WAIT_CTS;
                    end
                end
                WAIT_CTS: begin
                    if (!cts_sync) begin
                        tx      <= 1'b0;
                        clk_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
`ifdef DTI_BOOST_TX_PARITY_EN
                        par     <= shreg[0];
`endif
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // Bytes are contiguous in shreg, so one right shift
                // per bit walks straight into the next byte.
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef DTI_BOOST_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
`ifdef DTI_BOOST_TX_PARITY_EN
                            par     <= par ^ shreg[0];
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef DTI_BOOST_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == BYTE_MAX) begin
                            tx_done    <= 1'b1;
                            tx_ready_q <= 1'b1;
                            tx_busy    <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= WAIT_CTS;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dti_boost_tx.sv
// Directed bench for dti_boost_tx at CLKS_PER_BIT=4, 32-bit words.
// Honours DTI_BOOST_TX_PARITY_EN for the frame length and parity bit.
module tb_dti_boost_tx;

    localparam int CPB = 4;
`ifdef DTI_BOOST_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk;
    logic reset_n;
    logic cts_n;
    logic tx;
    logic tx_busy;
    logic tx_done;

    int total;
    int bad;

    dti_boost_tx_if #(.DATA_WIDTH(32)) bus ();

    dti_boost_tx #(
        .DATA_WIDTH  (32),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .cts_n  (cts_n),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] word;
        logic [3:0]  par;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    // Called at the negedge of cycle N (request cycle); returns at N+2.
    task automatic accept(input logic [31:0] w);
        bus.tx_data_in = w;
        bus.tx_wr_req  = 1'b1;
        chk("ready_before_acc", bus.tx_ready, 1'b1);
        @(negedge clk);
        bus.tx_wr_req  = 1'b0;
        bus.tx_data_in = ~w;
        chk("busy_after_acc", tx_busy, 1'b1);
        chk("ready_after_acc", bus.tx_ready, 1'b0);
        chk("tx_idle_after_acc", tx, 1'b1);
        @(negedge clk);
    endtask

    // Entered at the first start-bit cycle; returns in the tx_done cycle.
    // hold>0 raises cts_n during byte 0 data and keeps it for hold cycles.
    task automatic frame_word(input logic [31:0] w, input logic [3:0] par,
                              input int hold);
        logic [7:0] byt;
        logic       exp;
        for (int k = 0; k < 4; k++) begin
            byt = w[8*k +: 8];
            for (int b = 0; b < FB; b++) begin
                if (b == 0) exp = 1'b0;
                else if (b <= 8) exp = byt[b-1];
                else if (b == FB - 1) exp = 1'b1;
                else exp = par[k];
                for (int c = 0; c < CPB; c++) begin
                    if (hold > 0 && k == 0 && b == 4 && c == 0) cts_n = 1'b1;
                    chk($sformatf("tx_byte%0d_bit%0d", k, b), tx, exp);
                    chk("ready_low_in_frame", bus.tx_ready, 1'b0);
                    chk("done_low_in_frame", tx_done, 1'b0);
                    @(negedge clk);
                end
            end
            if (k < 3) begin
                chk("gap_tx_high", tx, 1'b1);
                chk("gap_no_done", tx_done, 1'b0);
                chk("gap_busy", tx_busy, 1'b1);
                if (hold > 0 && k == 0) begin
                    repeat (hold) begin
                        @(negedge clk);
                        chk("cts_hold_tx_high", tx, 1'b1);
                        chk("cts_hold_busy", tx_busy, 1'b1);
                    end
                    cts_n = 1'b0;
                    @(negedge clk);
                    chk("cts_sync1_tx_high", tx, 1'b1);
                    @(negedge clk);
                    chk("cts_sync2_tx_high", tx, 1'b1);
                end
                @(negedge clk);
            end else begin
                chk("done_pulse", tx_done, 1'b1);
                chk("ready_at_done", bus.tx_ready, 1'b1);
                chk("busy_clear_at_done", tx_busy, 1'b0);
                chk("tx_idle_at_done", tx, 1'b1);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // Parity column: bit k is the even parity of byte k.
        vecs[0] = '{word: 32'h1234_5678, par: 4'b0100};
        vecs[1] = '{word: 32'h0000_0178, par: 4'b0010};
        vecs[2] = '{word: 32'hDEAD_BEEF, par: 4'b0101};
        vecs[3] = '{word: 32'h8000_0001, par: 4'b1001};

        reset_n        = 1'b0;
        cts_n          = 1'b0;
        bus.tx_wr_req  = 1'b0;
        bus.tx_data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", bus.tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_ready", bus.tx_ready, 1'b1);

        for (int i = 0; i < 4; i++) begin
            accept(vecs[i].word);
            frame_word(vecs[i].word, vecs[i].par, 0);
            @(negedge clk);
            chk("idle_after_word", tx_done, 1'b0);
            chk("idle_tx_high", tx, 1'b1);
        end

        // CTS dropped mid byte 0: byte completes, byte 1 waits.
        accept(32'h1234_5678);
        frame_word(32'h1234_5678, 4'b0100, 20);
        @(negedge clk);

        // CTS not clear at acceptance, released after 50 cycles.
        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        accept(32'hA5A5_A5A5);
        repeat (50) begin
            chk("cts_wait_tx_high", tx, 1'b1);
            chk("cts_wait_busy", tx_busy, 1'b1);
            @(negedge clk);
        end
        cts_n = 1'b0;
        chk("cts_rel_tx_high", tx, 1'b1);
        @(negedge clk);
        chk("cts_rel1_tx_high", tx, 1'b1);
        @(negedge clk);
        chk("cts_rel2_tx_high", tx, 1'b1);
        @(negedge clk);
        frame_word(32'hA5A5_A5A5, 4'b0000, 0);
        @(negedge clk);

        // Back-to-back words with request held high.
        bus.tx_data_in = 32'h0000_0000;
        bus.tx_wr_req  = 1'b1;
        chk("b2b_ready", bus.tx_ready, 1'b1);
        @(negedge clk);
        bus.tx_data_in = 32'hFFFF_FFFF;
        chk("b2b_ready_low", bus.tx_ready, 1'b0);
        @(negedge clk);
        frame_word(32'h0000_0000, 4'b0000, 0);
        @(negedge clk);
        bus.tx_wr_req = 1'b0;
        chk("b2b_second_busy", tx_busy, 1'b1);
        chk("b2b_second_ready", bus.tx_ready, 1'b0);
        @(negedge clk);
        frame_word(32'hFFFF_FFFF, 4'b0000, 0);
        @(negedge clk);

        // Reset during byte 1 data bit 3 (0x56 bit 3 = 0).
        accept(32'h1234_5678);
        repeat (FB * CPB + 1 + CPB * 4) @(negedge clk);
        chk("pre_rst_tx_low", tx, 1'b0);
        chk("pre_rst_busy", tx_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_ready", bus.tx_ready, 1'b1);
        chk("mid_rst_busy", tx_busy, 1'b0);
        chk("mid_rst_done", tx_done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            chk("post_abort_tx", tx, 1'b1);
            chk("post_abort_done", tx_done, 1'b0);
            chk("post_abort_busy", tx_busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
